dmem_access_ctrl: RTL

Sequences data-memory accesses for the pipeline's MEM stage against a single-port synchronous word RAM with configurable read latency. It accepts one load or store request at a time and formats load data with sign or zero extension. Sub-word stores are performed as read-modify-write. Misaligned and illegal accesses are reported. It sits between the MEM stage, which stalls on busy, and the data RAM.

---
 rtl/dmem_pkg.sv | 45 ++++
 rtl/dmem_lane_fmt.sv | 62 ++++++
 rtl/dmem_access_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - access codes, FSM encoding and access-classification helpers
package dmem_pkg;

    localparam logic [3:0] ACC_LW  = 4'b0000;
    localparam logic [3:0] ACC_LH  = 4'b0001;
    localparam logic [3:0] ACC_LB  = 4'b0010;
    localparam logic [3:0] ACC_LBU = 4'b0011;
    localparam logic [3:0] ACC_LHU = 4'b0100;
    localparam logic [3:0] ACC_SW  = 4'b1000;
    localparam logic [3:0] ACC_SH  = 4'b1001;
    localparam logic [3:0] ACC_SB  = 4'b1011;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    function automatic logic is_load(input logic [3:0] acc);
        case (acc)
            ACC_LW, ACC_LH, ACC_LB, ACC_LBU, ACC_LHU: return 1'b1;
            default:                                  return 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input logic [3:0] acc);
        case (acc)
            ACC_SW, ACC_SH, ACC_SB: return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

    // Halfwords may sit at offsets 0..2 because the RAM word is read whole;
    // only an access spilling past byte 3 is rejected.
    function automatic logic is_misaligned(input logic [3:0] acc, input logic [1:0] off);
        case (acc)
            ACC_LW, ACC_SW:          return off != 2'd0;
            ACC_LH, ACC_LHU, ACC_SH: return off == 2'd3;
            default:                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// rtl/dmem_lane_fmt.sv - load extraction/extension and sub-word store merge
module dmem_lane_fmt
    import dmem_pkg::*;
(
    input  logic [3:0]  acc,
    input  logic [1:0]  off,
    input  logic [31:0] old,
    input  logic [31:0] wd,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [15:0] half_sel;
    logic [7:0]  byte_sel;
    logic [4:0]  bit_off;

    assign bit_off = {off, 3'b000};

    // Pick the addressed halfword and byte lane out of the old word
    always_comb begin
        half_sel = old[31:16];
        case (off)
            2'd0:    half_sel = old[15:0];
            2'd1:    half_sel = old[23:8];
            2'd2:    half_sel = old[31:16];
            default: half_sel = old[31:16];
        endcase
        byte_sel = old[bit_off +: 8];
    end

    // Right-align and extend the loaded field
    always_comb begin
        load_data = 32'd0;
        case (acc)
            ACC_LW:  load_data = old;
            ACC_LH:  load_data = {{16{half_sel[15]}}, half_sel};
            ACC_LHU: load_data = {16'd0, half_sel};
            ACC_LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
            ACC_LBU: load_data = {24'd0, byte_sel};
            default: load_data = 32'd0;
        endcase
    end

    // Build the full word to write back: new field over the old word
    always_comb begin
        merge_data = old;
        case (acc)
            ACC_SW: merge_data = wd;
            ACC_SH: begin
                case (off)
                    2'd0:    merge_data = {old[31:16], wd[15:0]};
                    2'd1:    merge_data = {old[31:24], wd[15:0], old[7:0]};
                    2'd2:    merge_data = {wd[15:0], old[15:0]};
                    default: merge_data = old;
                endcase
            end
            ACC_SB:  merge_data[bit_off +: 8] = wd[7:0];
            default: merge_data = old;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - MEM-stage data RAM sequencer with sub-word RMW
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_access,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy,
    output logic [31:0] mem_addr,
    output logic        mem_re,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

    state_t      state, state_nxt;
    logic [31:0] addr_q;
    logic [3:0]  acc_q;
    logic [31:0] wdata_q;
    logic [31:0] old_q;
    logic        err_q;
    logic [1:0]  cnt_q;

    logic        accept;
    logic        req_err;
    logic        wait_done;
    logic [31:0] fmt_old;
    logic [31:0] load_data;
    logic [31:0] merge_data;

    assign accept    = req_valid && req_ready;
    assign req_err   = !(is_load(req_access) || is_store(req_access))
                       || is_misaligned(req_access, req_addr[1:0]);
    assign wait_done = (state == ST_WAIT) && (cnt_q == 2'd0);

    // In WAIT the formatter sees the live RAM word so the load result can be
    // registered on the capture edge; in WRITE it merges against old_q.
    assign fmt_old = (state == ST_WAIT) ? mem_rdata : old_q;

    dmem_lane_fmt u_lane_fmt (
        .acc        (acc_q),
        .off        (addr_q[1:0]),
        .old        (fmt_old),
        .wd         (wdata_q),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_wdata = merge_data;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (req_err) begin
                        state_nxt = ST_RESP;
                    end else if (req_access == ACC_SW) begin
                        state_nxt = ST_WRITE;
                    end else begin
                        state_nxt = ST_READ;
                    end
                end
            end
            ST_READ:  state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (wait_done) begin
                    state_nxt = is_load(acc_q) ? ST_RESP : ST_WRITE;
                end
            end
            ST_WRITE: state_nxt = ST_RESP;
            ST_RESP:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Moore output decode
    always_comb begin
        req_ready  = 1'b0;
        busy       = 1'b1;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
            end
            ST_READ:  mem_re = 1'b1;
            ST_WRITE: mem_we = 1'b1;
            ST_RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
            end
            default: ;
        endcase
    end

    // Request latch, read-latency counter, old-word capture and response data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q     <= 32'd0;
            acc_q      <= 4'd0;
            wdata_q    <= 32'd0;
            old_q      <= 32'd0;
            err_q      <= 1'b0;
            cnt_q      <= 2'd0;
            resp_rdata <= 32'd0;
        end else begin
            if (accept) begin
                addr_q  <= req_addr;
                acc_q   <= req_access;
                wdata_q <= req_wdata;
                err_q   <= req_err;
                if (req_err) begin
                    resp_rdata <= 32'd0;
                end
            end
            if (state == ST_READ) begin
                cnt_q <= CNT_INIT;
            end
            if (state == ST_WAIT) begin
                if (cnt_q == 2'd0) begin
                    old_q <= mem_rdata;
                    if (is_load(acc_q)) begin
                        resp_rdata <= load_data;
                    end
                end else begin
                    cnt_q <= cnt_q - 2'd1;
                end
            end
            if (state == ST_WRITE) begin
                resp_rdata <= 32'd0;
            end
        end
    end

endmodule
